// File: rtl/vx_mem_responder.sv
// vx_mem_responder: target-side responder for the Vortex external memory port.
// Byte-enabled line storage, fixed-latency read pipeline, and a credit-limited
// in-order response queue.
// Optional: define VX_MEM_RESPONDER_PERF_EN to add perf_reads, perf_writes and
// perf_stall_cycles counters.
module vx_mem_responder #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int NUM_LINES      = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
`ifdef VX_MEM_RESPONDER_PERF_EN
  ,
  output logic [31:0]             perf_reads,
  output logic [31:0]             perf_writes,
  output logic [31:0]             perf_stall_cycles
`endif
);

  localparam int BYTEEN_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W        = $clog2(NUM_LINES);
  localparam int QW           = $clog2(RSP_QUEUE_SIZE);
  localparam int CW           = QW + 1;

  logic [CW-1:0]         outstanding;
  logic                  req_fire;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  rsp_fire;
  logic [IDX_W-1:0]      req_idx;
  logic                  unused_addr_hi;

  logic [DATA_WIDTH-1:0] mem_array [NUM_LINES];

  logic [LATENCY-1:0]    pipe_valid;
  logic [TAG_WIDTH-1:0]  pipe_tag  [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];

  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] fifo_data [RSP_QUEUE_SIZE];

  // Handshakes, credit-based ready and queue status.
  always_comb begin
    // Held low during reset; otherwise only the credit count gates acceptance.
    mem_req_ready  = !reset && (outstanding < CW'(RSP_QUEUE_SIZE));
    req_fire       = mem_req_valid && mem_req_ready;
    rd_accept      = req_fire && !mem_req_rw;
    wr_accept      = req_fire && mem_req_rw;
    req_idx        = mem_req_addr[IDX_W-1:0];
    unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:IDX_W];
    fifo_empty     = (wr_ptr == rd_ptr);
    fifo_full      = (wr_ptr[QW] != rd_ptr[QW]) && (wr_ptr[QW-1:0] == rd_ptr[QW-1:0]);
    // Credits make a push into a full queue unreachable; the guard is defensive.
    push           = pipe_valid[LATENCY-1] && !fifo_full;
    mem_rsp_valid  = !fifo_empty;
    mem_rsp_data   = fifo_data[rd_ptr[QW-1:0]];
    mem_rsp_tag    = fifo_tag[rd_ptr[QW-1:0]];
    rsp_fire       = mem_rsp_valid && mem_rsp_ready;
    busy           = (outstanding != '0);
  end

  // Outstanding-read credit counter: reads in pipeline plus queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (rd_accept && !rsp_fire) begin
      outstanding <= outstanding + CW'(1);
    end else if (!rd_accept && rsp_fire) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  // Byte-enabled line writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < BYTEEN_WIDTH; i++) begin
        if (mem_req_byteen[i]) begin
          mem_array[req_idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
        end
      end
    end
  end

  // Read pipeline valid bits; cleared by reset so in-flight reads are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Read pipeline payload: line sampled at accept, then shifted every cycle.
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      pipe_tag[0]  <= mem_req_tag;
      pipe_data[0] <= mem_array[req_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_tag[i]  <= pipe_tag[i-1];
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  // Response queue pointers, each with an extra wrap bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (rsp_fire) begin
        rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

  // Response queue storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tag[wr_ptr[QW-1:0]]  <= pipe_tag[LATENCY-1];
      fifo_data[wr_ptr[QW-1:0]] <= pipe_data[LATENCY-1];
    end
  end

`ifdef VX_MEM_RESPONDER_PERF_EN
  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reads        <= '0;
      perf_writes       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (rd_accept) begin
        perf_reads <= perf_reads + 32'd1;
      end
      if (wr_accept) begin
        perf_writes <= perf_writes + 32'd1;
      end
      if (mem_req_valid && !mem_req_ready) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed self-checking bench for vx_mem_responder (default parameters).
module tb_vx_mem_responder;

  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int NL = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req_valid = 1'b0;
  logic          mem_req_rw = 1'b0;
  logic [DW/8-1:0] mem_req_byteen = '0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [DW-1:0] mem_req_data = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready = 1'b0;
  logic          busy;
`ifdef VX_MEM_RESPONDER_PERF_EN
  logic [31:0]   perf_reads;
  logic [31:0]   perf_writes;
  logic [31:0]   perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  vx_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .busy           (busy)
`ifdef VX_MEM_RESPONDER_PERF_EN
    ,
    .perf_reads        (perf_reads),
    .perf_writes       (perf_writes),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW/8-1:0] be,
                          input logic [DW-1:0] data);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = data;
    tick();
    mem_req_valid  = 1'b0;
  endtask

  // Issues one read, waits (bounded) for its response, captures it and pops it.
  // lat is the number of cycles from the accept edge to mem_rsp_valid, or -1.
  task automatic read_line(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                           output logic [DW-1:0] data, output logic [TW-1:0] rtag,
                           output int lat);
    mem_rsp_ready  = 1'b0;
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b0;
    mem_req_addr   = addr;
    mem_req_tag    = tag;
    mem_req_byteen = '0;
    tick();
    mem_req_valid  = 1'b0;
    lat  = -1;
    data = '0;
    rtag = '0;
    for (int k = 1; k <= 20; k++) begin
      if (lat < 0) begin
        tick();
        if (mem_rsp_valid) begin
          lat  = k;
          data = mem_rsp_data;
          rtag = mem_rsp_tag;
        end
      end
    end
    if (lat >= 0) begin
      mem_rsp_ready = 1'b1;
      tick();
      mem_rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (mem_rsp_valid !== 1'b0 || busy !== 1'b0 || mem_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid/busy/ready got %b%b%b expected 000",
               mem_rsp_valid, busy, mem_req_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (mem_req_ready !== 1'b1 || busy !== 1'b0 || mem_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: ready/busy/valid got %b%b%b expected 100",
               mem_req_ready, busy, mem_rsp_valid);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    int            lat;
    do_write(26'h10, '1, {64{8'hA5}});
    read_line(26'h10, 8'h03, d, t, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL read_latency: got %0d expected 4", lat);
    end
    checks++;
    if (d !== {64{8'hA5}}) begin
      errors++;
      $display("FAIL read_data: got %h expected %h", d, {64{8'hA5}});
    end
    checks++;
    if (t !== 8'h03) begin
      errors++;
      $display("FAIL read_tag: got %h expected 03", t);
    end
  endtask

  task automatic test_partial_write();
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    logic [TW-1:0] t;
    int            lat;
    exp_d = '0;
    exp_d[7:0] = 8'hFF;
    do_write(26'h30, '1, '0);
    // Data is all ones: only byte 0 may land.
    do_write(26'h30, 64'h1, '1);
    read_line(26'h30, 8'h09, d, t, lat);
    checks++;
    if (d !== exp_d || lat !== 4) begin
      errors++;
      $display("FAIL partial_write: got %h lat %0d expected %h lat 4", d, lat, exp_d);
    end
  endtask

  task automatic test_backpressure();
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_before_%0d: got %b expected 1", i, mem_req_ready);
      end
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = AW'(i);
      mem_req_tag   = TW'(i);
      tick();
    end
    mem_req_valid = 1'b0;
    checks++;
    if (mem_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_full: got %b expected 0", mem_req_ready);
    end
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (mem_req_ready !== 1'b0 || mem_rsp_valid !== 1'b1 || mem_rsp_tag !== 8'h00) begin
      errors++;
      $display("FAIL bp_held: ready/valid got %b%b tag %h expected 01 tag 00",
               mem_req_ready, mem_rsp_valid, mem_rsp_tag);
    end
    mem_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TW'(i)) begin
        errors++;
        $display("FAIL bp_order_%0d: valid %b tag %h expected valid 1 tag %h",
                 i, mem_rsp_valid, mem_rsp_tag, TW'(i));
      end
      tick();
      if (i == 0) begin
        checks++;
        if (mem_req_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_after_pop: got %b expected 1", mem_req_ready);
        end
      end
    end
    mem_rsp_ready = 1'b0;
    checks++;
    if (mem_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: valid/busy got %b%b expected 00", mem_rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    mem_rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: got %b expected 1", i, mem_req_ready);
      end
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = AW'(i);
      mem_req_tag   = TW'(8'h40 + i);
      tick();
      if (i >= 4) begin
        checks++;
        if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TW'(8'h40 + i - 4) || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_rsp_%0d: valid %b busy %b tag %h expected 1 1 %h",
                   i, mem_rsp_valid, busy, mem_rsp_tag, TW'(8'h40 + i - 4));
        end
      end
    end
    mem_req_valid = 1'b0;
    for (int j = 16; j < 20; j++) begin
      tick();
      checks++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TW'(8'h40 + j - 4)) begin
        errors++;
        $display("FAIL b2b_drain_%0d: valid %b tag %h expected 1 %h",
                 j, mem_rsp_valid, mem_rsp_tag, TW'(8'h40 + j - 4));
      end
    end
    tick();
    mem_rsp_ready = 1'b0;
    checks++;
    if (mem_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: valid/busy got %b%b expected 00", mem_rsp_valid, busy);
    end
  endtask

  task automatic test_reset_midflight();
    int            seen;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    int            lat;
    seen = 0;
    mem_rsp_ready = 1'b0;
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 26'h10;
    mem_req_tag   = 8'h77;
    tick();
    mem_req_valid = 1'b0;
    tick();
    if (mem_rsp_valid) seen++;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (mem_rsp_valid !== 1'b0 || busy !== 1'b0 || mem_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: valid/busy/ready got %b%b%b expected 000",
               mem_rsp_valid, busy, mem_req_ready);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_rsp: valid seen %0d cycles expected 0", seen);
    end
    checks++;
    if (busy !== 1'b0 || mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release: busy/ready got %b%b expected 01", busy, mem_req_ready);
    end
    read_line(26'h10, 8'h05, d, t, lat);
    checks++;
    if (d !== {64{8'hA5}} || t !== 8'h05 || lat !== 4) begin
      errors++;
      $display("FAIL midreset_retained: data %h tag %h lat %0d expected %h 05 4",
               d, t, lat, {64{8'hA5}});
    end
  endtask

  task automatic test_alias();
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [TW-1:0] t;
    int            lat;
`ifdef VX_MEM_RESPONDER_PERF_EN
    logic [31:0]   r0;
    logic [31:0]   w0;
    r0 = perf_reads;
    w0 = perf_writes;
`endif
    do_write(AW'(26'h50 + NL), '1, {64{8'h5A}});
    read_line(26'h50, 8'h11, d0, t, lat);
    read_line(AW'(26'h50 + NL), 8'h12, d1, t, lat);
    checks++;
    if (d0 !== {64{8'h5A}} || d1 !== {64{8'h5A}}) begin
      errors++;
      $display("FAIL alias: got %h / %h expected %h", d0, d1, {64{8'h5A}});
    end
`ifdef VX_MEM_RESPONDER_PERF_EN
    checks++;
    if (perf_reads - r0 !== 32'd2 || perf_writes - w0 !== 32'd1) begin
      errors++;
      $display("FAIL perf: reads +%0d writes +%0d expected +2 +1",
               perf_reads - r0, perf_writes - w0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_alias();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
